regfile_port: RTL and testbench
===============================

# regfile_port

Initiator-side port controller that drives the CPU register file's strobe/acknowledge read and write interface on behalf of the pipeline. It accepts one read request (rs1/rs2 pair) from decode and one write request (rd/value) from writeback through valid/ready handshakes. It serialises them onto the register file port with writes first, waits for each acknowledge, and returns read data or write completion upstream. A cycle counter flags a register file that fails to acknowledge.

## Interface
Parameters:
- ACK_TIMEOUT, 16: cycles to wait for an acknowledge before abandoning a transaction; must be at least 2.

Ports:
- clk_i  in  1  clock; one clock; all logic on posedge.
- rst_i  in  1  reset, synchronous, active-high.
- rd_valid_i  in  1  read request valid.
- rd_ready_o  out  1  read slot empty; request accepted when valid&ready.
- rd_rs1_i  in  5  first source register index.
- rd_rs2_i  in  5  second source register index.
- rd_done_o  out  1  one-cycle pulse: read data valid.
- rd_rs1_data_o  out  32  rs1 value, held until next rd_done_o.
- rd_rs2_data_o  out  32  rs2 value, held until next rd_done_o.
- wr_valid_i  in  1  write request valid.
- wr_ready_o  out  1  write slot empty.
- wr_rd_i  in  5  destination register index.
- wr_data_i  in  32  value to write.
- wr_done_o  out  1  one-cycle pulse: write complete.
- err_o  out  1  one-cycle pulse, coincident with rd_done_o/wr_done_o of a timed-out transaction.
- stb_read_o  out  1  read strobe to register file.
- op_rs1_o, op_rs2_o  out  5 each  read indices.
- ack_read_i  in  1  read acknowledge.
- reg_rs1_i, reg_rs2_i  in  32 each  read data.
- stb_write_o  out  1  write strobe.
- op_rd_o  out  5  write index.
- reg_rd_o  out  32  write data.
- ack_write_i  in  1  write acknowledge.

## Operation
- One-deep holding slot per direction: a read slot holding rs1/rs2 and a write slot holding rd/data. A slot loads on valid&ready and frees on its done pulse.
- FSM states IDLE, WR_WAIT, RD_WAIT:
  - IDLE: if the write slot is full, pulse stb_write_o and go to WR_WAIT. Else if the read slot is full, pulse stb_read_o and go to RD_WAIT.
  - WR_WAIT: on ack_write_i, pulse wr_done_o, free the write slot, go to IDLE.
  - RD_WAIT: on ack_read_i, latch reg_rs1_i/reg_rs2_i, pulse rd_done_o, free the read slot, go to IDLE.
- Writes always take priority over reads. A read issued after a pending write to the same index therefore returns the new value (RAW-safe).
- Write with wr_rd_i = 0: no strobe is issued. wr_done_o pulses on the cycle after acceptance and x0 stays 0.
- Read of index 0 is issued normally; the register file returns 0.
- Strobes are single-cycle pulses. op_* and reg_rd_o are driven from the slots and held stable from strobe until ack.
- Only one register file transaction is ever outstanding.
- Timeout: a wait counter clears on strobe and increments in WR_WAIT/RD_WAIT.
  - Reaching ACK_TIMEOUT produces the normal done pulse plus err_o, frees the slot, and returns to IDLE.
  - On a timed-out read, the data outputs keep their previous values.
- Ack received in IDLE (stray) is ignored.

## Timing
- Reset values: rd_ready_o=1, wr_ready_o=1, all strobes/done/err=0, op_*=0, reg_rd_o=0, data outputs=0, state IDLE, slots empty.
- Read, idle path:
  - req accepted at edge 0, strobe high cycle 1.
  - Register file ack high cycle 2.
  - rd_done_o high cycle 3, with data valid the same cycle.
  - 3-cycle latency.
- Write path is the same (3 cycles); x0 write takes 1 cycle.
- Read and write accepted on the same edge: write completes at cycle 3, read strobe at cycle 4, rd_done_o at cycle 6.
- The ready for a slot reasserts on the cycle after its done pulse. Back-to-back same-direction throughput is 1 per 4 cycles.
- Reset mid-transaction: everything returns to reset values next cycle and the in-flight request is dropped. The register file shares rst_i, so no late ack arrives.

## Structure
- Shared package: FSM state enum (IDLE, WR_WAIT, RD_WAIT) and register-index width constant (5).
- ACK_TIMEOUT stays a module parameter.
- No sub-module; the counter and two slots are inline.

## Test plan
- Reset, then read rs1=3, rs2=0 against a register file with x3=0x1234_5678 -> stb_read_o at cycle 1, rd_done_o at cycle 3, rd_rs1_data_o=0x1234_5678, rd_rs2_data_o=0.
- Write x5=0xDEAD_BEEF and read rs1=5 on the same edge -> write strobe first, wr_done_o at cycle 3, rd_done_o at cycle 6 returning 0xDEAD_BEEF.
- Write x0=0xFFFF_FFFF -> no stb_write_o, wr_done_o at cycle 1; a later read of x0 returns 0.
- Stub register file never acks, ACK_TIMEOUT=16 -> rd_done_o and err_o pulse together 16 cycles after the strobe; data outputs unchanged; rd_ready_o returns to 1.
- Assert rst_i in RD_WAIT, the cycle before ack -> no rd_done_o, all outputs at reset values, readies=1.
- 8 back-to-back reads with valid held high -> one strobe every 4 cycles, each rd_done_o matches a scoreboard, ready low while the slot is full.

Source files
------------

// File: rtl/regfile_port_pkg.sv
// Shared types for the register file port controller: FSM states and the
// register index / data widths.
package regfile_port_pkg;

  localparam int REG_IDX_W = 5;
  localparam int DATA_W    = 32;

  typedef enum logic [1:0] {
    IDLE,
    WR_WAIT,
    RD_WAIT
  } state_e;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;
  typedef logic [DATA_W-1:0]    reg_data_t;

endpackage

// File: rtl/regfile_port_if.sv
// Upstream read/write request handshakes plus the strobe/acknowledge bus to
// the register file. The controller uses the master view.
interface regfile_port_if;
  import regfile_port_pkg::*;

  logic      rd_valid_i;
  logic      rd_ready_o;
  reg_idx_t  rd_rs1_i;
  reg_idx_t  rd_rs2_i;
  logic      rd_done_o;
  reg_data_t rd_rs1_data_o;
  reg_data_t rd_rs2_data_o;

  logic      wr_valid_i;
  logic      wr_ready_o;
  reg_idx_t  wr_rd_i;
  reg_data_t wr_data_i;
  logic      wr_done_o;

  logic      err_o;

  logic      stb_read_o;
  reg_idx_t  op_rs1_o;
  reg_idx_t  op_rs2_o;
  logic      ack_read_i;
  reg_data_t reg_rs1_i;
  reg_data_t reg_rs2_i;

  logic      stb_write_o;
  reg_idx_t  op_rd_o;
  reg_data_t reg_rd_o;
  logic      ack_write_i;

  modport master (
    input  rd_valid_i, rd_rs1_i, rd_rs2_i,
    input  wr_valid_i, wr_rd_i, wr_data_i,
    input  ack_read_i, reg_rs1_i, reg_rs2_i, ack_write_i,
    output rd_ready_o, rd_done_o, rd_rs1_data_o, rd_rs2_data_o,
    output wr_ready_o, wr_done_o, err_o,
    output stb_read_o, op_rs1_o, op_rs2_o,
    output stb_write_o, op_rd_o, reg_rd_o
  );

  modport slave (
    output rd_valid_i, rd_rs1_i, rd_rs2_i,
    output wr_valid_i, wr_rd_i, wr_data_i,
    output ack_read_i, reg_rs1_i, reg_rs2_i, ack_write_i,
    input  rd_ready_o, rd_done_o, rd_rs1_data_o, rd_rs2_data_o,
    input  wr_ready_o, wr_done_o, err_o,
    input  stb_read_o, op_rs1_o, op_rs2_o,
    input  stb_write_o, op_rd_o, reg_rd_o
  );

endinterface

// File: rtl/regfile_port.sv
// Serialises one pending read and one pending write onto the register file
// strobe/ack port, writes first, with an ack timeout that flags err_o.
module regfile_port
  import regfile_port_pkg::*;
#(
  parameter int ACK_TIMEOUT = 16
) (
  input logic            clk_i,
  input logic            rst_i,
  regfile_port_if.master bus
);

  localparam int               CNT_W     = $clog2(ACK_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(ACK_TIMEOUT);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;

  logic      rd_full_q, rd_full_d;
  reg_idx_t  rs1_q, rs1_d, rs2_q, rs2_d;
  logic      wr_full_q, wr_full_d;
  reg_idx_t  wr_idx_q, wr_idx_d;
  reg_data_t wr_val_q, wr_val_d;

  logic      stb_read_q, stb_read_d;
  logic      stb_write_q, stb_write_d;
  logic      rd_done_q, rd_done_d;
  logic      wr_done_q, wr_done_d;
  logic      err_q, err_d;
  reg_data_t rs1_data_q, rs1_data_d;
  reg_data_t rs2_data_q, rs2_data_d;

  logic rd_ready, wr_ready, rd_acc, wr_acc, wr_x0, timeout;

  // A slot stays closed through its done cycle so ready returns one cycle later.
  assign rd_ready = ~rd_full_q & ~rd_done_q;
  assign wr_ready = ~wr_full_q & ~wr_done_q;
  assign rd_acc   = bus.rd_valid_i & rd_ready;
  assign wr_acc   = bus.wr_valid_i & wr_ready;
  assign wr_x0    = (bus.wr_rd_i == '0);
  assign cnt_inc  = cnt_q + CNT_W'(1);
  assign timeout  = (cnt_inc == CNT_LIMIT);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rd_full_d   = rd_full_q;
    rs1_d       = rs1_q;
    rs2_d       = rs2_q;
    wr_full_d   = wr_full_q;
    wr_idx_d    = wr_idx_q;
    wr_val_d    = wr_val_q;
    stb_read_d  = 1'b0;
    stb_write_d = 1'b0;
    rd_done_d   = 1'b0;
    wr_done_d   = 1'b0;
    err_d       = 1'b0;
    rs1_data_d  = rs1_data_q;
    rs2_data_d  = rs2_data_q;

    if (rd_acc) begin
      rd_full_d = 1'b1;
      rs1_d     = bus.rd_rs1_i;
      rs2_d     = bus.rd_rs2_i;
    end

    // Writes to x0 never reach the register file; they complete immediately.
    if (wr_acc) begin
      if (wr_x0) begin
        wr_done_d = 1'b1;
      end else begin
        wr_full_d = 1'b1;
        wr_idx_d  = bus.wr_rd_i;
        wr_val_d  = bus.wr_data_i;
      end
    end

    unique case (state_q)
      IDLE: begin
        if (wr_full_q | (wr_acc & ~wr_x0)) begin
          stb_write_d = 1'b1;
          cnt_d       = '0;
          state_d     = WR_WAIT;
        end else if (rd_full_q | rd_acc) begin
          stb_read_d = 1'b1;
          cnt_d      = '0;
          state_d    = RD_WAIT;
        end
      end
      WR_WAIT: begin
        if (bus.ack_write_i | timeout) begin
          wr_done_d = 1'b1;
          err_d     = ~bus.ack_write_i;
          wr_full_d = 1'b0;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      RD_WAIT: begin
        if (bus.ack_read_i | timeout) begin
          rd_done_d = 1'b1;
          err_d     = ~bus.ack_read_i;
          rd_full_d = 1'b0;
          state_d   = IDLE;
          if (bus.ack_read_i) begin
            rs1_data_d = bus.reg_rs1_i;
            rs2_data_d = bus.reg_rs2_i;
          end
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rd_full_q   <= 1'b0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      wr_full_q   <= 1'b0;
      wr_idx_q    <= '0;
      wr_val_q    <= '0;
      stb_read_q  <= 1'b0;
      stb_write_q <= 1'b0;
      rd_done_q   <= 1'b0;
      wr_done_q   <= 1'b0;
      err_q       <= 1'b0;
      rs1_data_q  <= '0;
      rs2_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rd_full_q   <= rd_full_d;
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
      wr_full_q   <= wr_full_d;
      wr_idx_q    <= wr_idx_d;
      wr_val_q    <= wr_val_d;
      stb_read_q  <= stb_read_d;
      stb_write_q <= stb_write_d;
      rd_done_q   <= rd_done_d;
      wr_done_q   <= wr_done_d;
      err_q       <= err_d;
      rs1_data_q  <= rs1_data_d;
      rs2_data_q  <= rs2_data_d;
    end
  end

  assign bus.rd_ready_o    = rd_ready;
  assign bus.wr_ready_o    = wr_ready;
  assign bus.rd_done_o     = rd_done_q;
  assign bus.wr_done_o     = wr_done_q;
  assign bus.err_o         = err_q;
  assign bus.rd_rs1_data_o = rs1_data_q;
  assign bus.rd_rs2_data_o = rs2_data_q;
  assign bus.stb_read_o    = stb_read_q;
  assign bus.op_rs1_o      = rs1_q;
  assign bus.op_rs2_o      = rs2_q;
  assign bus.stb_write_o   = stb_write_q;
  assign bus.op_rd_o       = wr_idx_q;
  assign bus.reg_rd_o      = wr_val_q;

endmodule

// File: tb/tb_regfile_port.sv
// Bench for regfile_port: directed vector table, corner sequences, and a
// randomized run checked against a register-array reference model.
module tb_regfile_port;
  import regfile_port_pkg::*;

  logic clk, rst;
  regfile_port_if bus();

  regfile_port #(.ACK_TIMEOUT(16)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  logic [31:0] regs[32];
  logic [31:0] ref_regs[32];
  int  ack_dly  = 1;
  bit  mute     = 1'b0;
  bit  stray_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Register file responder: acks ack_dly cycles after a strobe.
  initial begin
    int rd_cd, wr_cd;
    rd_cd = 0;
    wr_cd = 0;
    for (int i = 0; i < 32; i++) regs[i] = '0;
    regs[3] = 32'h1234_5678;
    bus.ack_read_i  = 1'b0;
    bus.ack_write_i = 1'b0;
    bus.reg_rs1_i   = '0;
    bus.reg_rs2_i   = '0;
    forever begin
      @(posedge clk);
      #1;
      bus.ack_read_i  = 1'b0;
      bus.ack_write_i = 1'b0;
      bus.reg_rs1_i   = $urandom;
      bus.reg_rs2_i   = $urandom;
      if (rst) begin
        rd_cd = 0;
        wr_cd = 0;
      end else begin
        if (wr_cd > 0) begin
          wr_cd--;
          if (wr_cd == 0) begin
            bus.ack_write_i = 1'b1;
            if (bus.op_rd_o != 0) regs[bus.op_rd_o] = bus.reg_rd_o;
          end
        end
        if (rd_cd > 0) begin
          rd_cd--;
          if (rd_cd == 0) begin
            bus.ack_read_i = 1'b1;
            bus.reg_rs1_i  = regs[bus.op_rs1_o];
            bus.reg_rs2_i  = regs[bus.op_rs2_o];
          end
        end
        if (bus.stb_write_o && !mute) wr_cd = ack_dly;
        if (bus.stb_read_o && !mute)  rd_cd = ack_dly;
        if (stray_en) begin
          bus.ack_read_i  = 1'b1;
          bus.ack_write_i = 1'b1;
        end
      end
    end
  end

  // Event capture over a window; cycle numbers are 1-based after request cycle 0.
  int ev_sw, ev_sr, ev_wd, ev_rd, ev_err, n_sw, n_sr;
  logic [4:0]  cap_wa, cap_ra, cap_rb;
  logic [31:0] cap_w, cap_d1, cap_d2;

  task automatic observe(input int ncyc);
    ev_sw = 0; ev_sr = 0; ev_wd = 0; ev_rd = 0; ev_err = 0; n_sw = 0; n_sr = 0;
    for (int c = 1; c <= ncyc; c++) begin
      step();
      if (c == 1) begin
        bus.rd_valid_i = 1'b0;
        bus.wr_valid_i = 1'b0;
      end
      if (bus.stb_write_o) begin
        n_sw++;
        if (ev_sw == 0) begin ev_sw = c; cap_wa = bus.op_rd_o; cap_w = bus.reg_rd_o; end
      end
      if (bus.stb_read_o) begin
        n_sr++;
        if (ev_sr == 0) begin ev_sr = c; cap_ra = bus.op_rs1_o; cap_rb = bus.op_rs2_o; end
      end
      if (bus.wr_done_o && ev_wd == 0) ev_wd = c;
      if (bus.rd_done_o && ev_rd == 0) begin
        ev_rd  = c;
        cap_d1 = bus.rd_rs1_data_o;
        cap_d2 = bus.rd_rs2_data_o;
      end
      if (bus.err_o && ev_err == 0) ev_err = c;
    end
  endtask

  task automatic check_reset_vals(input string t);
    chk({t, "_readies"}, 64'({bus.rd_ready_o, bus.wr_ready_o}), 64'd3);
    chk({t, "_pulses"}, 64'({bus.stb_read_o, bus.stb_write_o, bus.rd_done_o,
                             bus.wr_done_o, bus.err_o}), 64'd0);
    chk({t, "_ops"}, 64'({bus.op_rs1_o, bus.op_rs2_o, bus.op_rd_o}), 64'd0);
    chk({t, "_wdata"}, 64'(bus.reg_rd_o), 64'd0);
    chk({t, "_rdata"}, {bus.rd_rs1_data_o, bus.rd_rs2_data_o}, 64'd0);
  endtask

  typedef struct {
    bit          is_wr;
    logic [4:0]  a;
    logic [4:0]  b;
    logic [31:0] wdata;
    int          exp_stb;
    int          exp_done;
    logic [31:0] exp_d1;
    logic [31:0] exp_d2;
  } vec_t;

  localparam int NV = 7;
  vec_t vecs[NV];

  logic [9:0]  rq[$];
  logic [36:0] wq[$];

  task automatic rnd_monitor();
    logic [36:0] w;
    logic [9:0]  r;
    if (bus.wr_done_o) begin
      chk("rnd_wr_err", 64'(bus.err_o), 64'd0);
      if (wq.size() == 0) begin
        n_chk++;
        $display("FAIL rnd_wr_done: actual=done-without-request required=none");
      end else begin
        w = wq.pop_front();
        if (w[36:32] != 0) ref_regs[w[36:32]] = w[31:0];
      end
    end
    if (bus.rd_done_o) begin
      chk("rnd_rd_err", 64'(bus.err_o), 64'd0);
      if (rq.size() == 0) begin
        n_chk++;
        $display("FAIL rnd_rd_done: actual=done-without-request required=none");
      end else begin
        r = rq.pop_front();
        chk("rnd_rd_data", {bus.rd_rs1_data_o, bus.rd_rs2_data_o},
            {ref_regs[r[9:5]], ref_regs[r[4:0]]});
      end
    end
  endtask

  initial begin
    logic [63:0] exq[$];
    logic [63:0] got;
    logic [4:0]  r1, r2;
    int acc, ndone, last_sr;
    bit just_acc;

    for (int i = 0; i < 32; i++) ref_regs[i] = '0;
    ref_regs[3] = 32'h1234_5678;

    vecs[0] = '{1'b0, 5'd3,  5'd0,  32'h0,         1, 3, 32'h1234_5678, 32'h0};
    vecs[1] = '{1'b1, 5'd0,  5'd0,  32'hFFFF_FFFF, 0, 1, 32'h0,         32'h0};
    vecs[2] = '{1'b0, 5'd0,  5'd3,  32'h0,         1, 3, 32'h0,         32'h1234_5678};
    vecs[3] = '{1'b1, 5'd31, 5'd0,  32'hA5A5_0F0F, 1, 3, 32'h0,         32'h0};
    vecs[4] = '{1'b0, 5'd31, 5'd3,  32'h0,         1, 3, 32'hA5A5_0F0F, 32'h1234_5678};
    vecs[5] = '{1'b1, 5'd1,  5'd0,  32'h0000_0001, 1, 3, 32'h0,         32'h0};
    vecs[6] = '{1'b0, 5'd1,  5'd31, 32'h0,         1, 3, 32'h0000_0001, 32'hA5A5_0F0F};

    rst = 1'b1;
    bus.rd_valid_i = 1'b0; bus.rd_rs1_i = '0; bus.rd_rs2_i = '0;
    bus.wr_valid_i = 1'b0; bus.wr_rd_i = '0;  bus.wr_data_i = '0;
    step();
    step();
    check_reset_vals("reset");
    rst = 1'b0;
    step();

    // Directed single transactions from idle.
    for (int i = 0; i < NV; i++) begin
      if (vecs[i].is_wr) begin
        bus.wr_valid_i = 1'b1; bus.wr_rd_i = vecs[i].a; bus.wr_data_i = vecs[i].wdata;
      end else begin
        bus.rd_valid_i = 1'b1; bus.rd_rs1_i = vecs[i].a; bus.rd_rs2_i = vecs[i].b;
      end
      observe(8);
      chk($sformatf("vec%0d_err", i), 64'(ev_err), 64'd0);
      if (vecs[i].is_wr) begin
        chk($sformatf("vec%0d_wr_stb_cycle", i), 64'(ev_sw), 64'(vecs[i].exp_stb));
        chk($sformatf("vec%0d_wr_done_cycle", i), 64'(ev_wd), 64'(vecs[i].exp_done));
        chk($sformatf("vec%0d_no_rd_stb", i), 64'(n_sr), 64'd0);
        if (vecs[i].exp_stb != 0)
          chk($sformatf("vec%0d_wr_bus", i), {27'd0, cap_wa, cap_w}, {27'd0, vecs[i].a, vecs[i].wdata});
        if (vecs[i].a != 0) ref_regs[vecs[i].a] = vecs[i].wdata;
      end else begin
        chk($sformatf("vec%0d_rd_stb_cycle", i), 64'(ev_sr), 64'(vecs[i].exp_stb));
        chk($sformatf("vec%0d_rd_done_cycle", i), 64'(ev_rd), 64'(vecs[i].exp_done));
        chk($sformatf("vec%0d_rd_idx", i), 64'({cap_ra, cap_rb}), 64'({vecs[i].a, vecs[i].b}));
        chk($sformatf("vec%0d_rd_data", i), {cap_d1, cap_d2}, {vecs[i].exp_d1, vecs[i].exp_d2});
        chk($sformatf("vec%0d_no_wr_stb", i), 64'(n_sw), 64'd0);
      end
    end

    // Write and read on the same edge: write goes first, read sees new value.
    bus.wr_valid_i = 1'b1; bus.wr_rd_i = 5'd5; bus.wr_data_i = 32'hDEAD_BEEF;
    bus.rd_valid_i = 1'b1; bus.rd_rs1_i = 5'd5; bus.rd_rs2_i = 5'd3;
    observe(10);
    chk("raw_cycles", 64'({8'(ev_sw), 8'(ev_wd), 8'(ev_sr), 8'(ev_rd)}), 64'({8'd1, 8'd3, 8'd4, 8'd6}));
    chk("raw_data", {cap_d1, cap_d2}, {32'hDEAD_BEEF, 32'h1234_5678});
    chk("raw_single_strobes", 64'({8'(n_sw), 8'(n_sr)}), 64'({8'd1, 8'd1}));
    ref_regs[5] = 32'hDEAD_BEEF;

    // Acks while idle must be ignored.
    stray_en = 1'b1;
    observe(3);
    stray_en = 1'b0;
    chk("stray_no_activity", 64'({8'(ev_wd), 8'(ev_rd), 8'(n_sw), 8'(n_sr)}), 64'd0);

    // Timeout on a read, then on a write.
    mute = 1'b1;
    bus.rd_valid_i = 1'b1; bus.rd_rs1_i = 5'd5; bus.rd_rs2_i = 5'd3;
    observe(20);
    chk("to_rd_stb_cycle", 64'(ev_sr), 64'd1);
    chk("to_rd_done_cycle", 64'(ev_rd), 64'd17);
    chk("to_rd_err_cycle", 64'(ev_err), 64'd17);
    chk("to_rd_data_held", {cap_d1, cap_d2}, {32'hDEAD_BEEF, 32'h1234_5678});
    chk("to_rd_ready_back", 64'(bus.rd_ready_o), 64'd1);
    bus.wr_valid_i = 1'b1; bus.wr_rd_i = 5'd7; bus.wr_data_i = 32'h7777_7777;
    observe(20);
    chk("to_wr_cycles", 64'({8'(ev_sw), 8'(ev_wd), 8'(ev_err)}), 64'({8'd1, 8'd17, 8'd17}));
    chk("to_wr_ready_back", 64'(bus.wr_ready_o), 64'd1);
    mute = 1'b0;
    bus.rd_valid_i = 1'b1; bus.rd_rs1_i = 5'd7; bus.rd_rs2_i = 5'd5;
    observe(8);
    chk("after_to_rd_data", {cap_d1, cap_d2}, {32'h0, 32'hDEAD_BEEF});

    // Reset while waiting for a read ack.
    bus.rd_valid_i = 1'b1; bus.rd_rs1_i = 5'd3; bus.rd_rs2_i = 5'd5;
    step();
    bus.rd_valid_i = 1'b0;
    chk("rstmid_stb", 64'(bus.stb_read_o), 64'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_reset_vals("rstmid");
    observe(5);
    chk("rstmid_dropped", 64'({8'(ev_rd), 8'(n_sr), 8'(ev_err)}), 64'd0);

    // Back-to-back reads with valid held high.
    acc = 0; ndone = 0; last_sr = -1; just_acc = 1'b0;
    for (int cyc = 0; cyc < 100 && ndone < 8; cyc++) begin
      if (acc < 8) begin
        bus.rd_valid_i = 1'b1;
        if (bus.rd_ready_o) begin
          r1 = 5'($urandom_range(0, 31));
          r2 = 5'($urandom_range(0, 31));
          bus.rd_rs1_i = r1;
          bus.rd_rs2_i = r2;
          exq.push_back({ref_regs[r1], ref_regs[r2]});
          acc++;
          just_acc = 1'b1;
        end
      end else begin
        bus.rd_valid_i = 1'b0;
      end
      step();
      if (just_acc) begin
        chk("b2b_ready_low", 64'(bus.rd_ready_o), 64'd0);
        just_acc = 1'b0;
      end
      if (bus.stb_read_o) begin
        if (last_sr >= 0) chk("b2b_stb_spacing", 64'(cyc - last_sr), 64'd4);
        last_sr = cyc;
      end
      if (bus.rd_done_o) begin
        if (exq.size() == 0) begin
          n_chk++;
          $display("FAIL b2b_done: actual=done-without-request required=none");
        end else begin
          got = exq.pop_front();
          chk("b2b_data", {bus.rd_rs1_data_o, bus.rd_rs2_data_o}, got);
          ndone++;
        end
      end
    end
    bus.rd_valid_i = 1'b0;
    chk("b2b_count", 64'(ndone), 64'd8);
    step();

    // Randomized traffic against the reference register array.
    for (int cyc = 0; cyc < 2000; cyc++) begin
      ack_dly = $urandom_range(1, 3);
      bus.rd_valid_i = ($urandom_range(0, 2) == 0);
      bus.rd_rs1_i   = 5'($urandom_range(0, 7));
      bus.rd_rs2_i   = 5'($urandom_range(0, 7));
      if (bus.rd_valid_i && bus.rd_ready_o) rq.push_back({bus.rd_rs1_i, bus.rd_rs2_i});
      bus.wr_valid_i = ($urandom_range(0, 3) == 0);
      bus.wr_rd_i    = 5'($urandom_range(0, 7));
      bus.wr_data_i  = $urandom;
      if (bus.wr_valid_i && bus.wr_ready_o) wq.push_back({bus.wr_rd_i, bus.wr_data_i});
      step();
      rnd_monitor();
    end
    bus.rd_valid_i = 1'b0;
    bus.wr_valid_i = 1'b0;
    for (int cyc = 0; cyc < 100 && (rq.size() != 0 || wq.size() != 0); cyc++) begin
      step();
      rnd_monitor();
    end
    chk("rnd_drain", 64'({16'(rq.size()), 16'(wq.size())}), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
